// File: rtl/rng_health_pkg.sv
// Shared types and defaults for the RNG health-monitor chain.
package rng_health_pkg;

  localparam int unsigned DEFAULT_N          = 20000;
  localparam int unsigned DEFAULT_FAIL_LIMIT = 3;
  localparam int unsigned DEFAULT_CNT_W      = 16;
  // Edges between the end of a window and its verdict sample:
  // one for the frequency stage register, one for ours.
  localparam int unsigned SAMPLE_OFFSET      = 2;

  typedef enum logic [1:0] {
    StWarmup,
    StRun,
    StAlarm
  } state_e;

endpackage

// File: rtl/rng_health_monitor_if.sv
// Bus between the health monitor and its surroundings (source side is master).
interface rng_health_monitor_if #(
  parameter int unsigned FAIL_LIMIT = 3,
  parameter int unsigned CNT_W      = 16
) ();

  localparam int unsigned StreakW = $clog2(FAIL_LIMIT + 1);

  logic               rand_in;
  logic               freq_pass;
  logic               alarm_clr;
  logic               bit_out;
  logic               bit_valid;
  logic               result_valid;
  logic               window_ok;
  logic               alarm;
  logic [StreakW-1:0] fail_streak;
  logic [CNT_W-1:0]   win_count;
  logic [CNT_W-1:0]   fail_count;

  modport master (
    output rand_in, freq_pass, alarm_clr,
    input  bit_out, bit_valid, result_valid, window_ok, alarm, fail_streak, win_count,
           fail_count
  );

  modport slave (
    input  rand_in, freq_pass, alarm_clr,
    output bit_out, bit_valid, result_valid, window_ok, alarm, fail_streak, win_count,
           fail_count
  );

endinterface

// File: rtl/rng_window_timer.sv
// Window timer: strobes sample_stb_o in the cycle before edges k*N+SAMPLE_OFFSET (k>=1).
module rng_window_timer
  import rng_health_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic clk,
  input  logic rst,
  output logic sample_stb_o
);

  localparam int unsigned     PhaseW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [PhaseW-1:0] PhaseLast   = PhaseW'(N - 1);
  // After edge e the phase equals e mod N, so the strobe sits at phase OFFSET-1.
  localparam logic [PhaseW-1:0] PhaseSample = PhaseW'((SAMPLE_OFFSET - 1) % N);

  logic [PhaseW-1:0] phase_q, phase_d;
  logic              armed_q, armed_d;

  // Modulo-N phase; armed once the first full window has elapsed.
  always_comb begin
    phase_d = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
    armed_d = armed_q | (phase_q == PhaseLast);
  end

  // Phase and arm registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      armed_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      armed_q <= armed_d;
    end
  end

  assign sample_stb_o = armed_q && (phase_q == PhaseSample);

endmodule

// File: rtl/rng_health_monitor.sv
// Health monitor: samples the frequency-test verdict per window, tracks statistics,
// raises a sticky alarm on consecutive failures and certifies the delayed bit stream.
module rng_health_monitor
  import rng_health_pkg::*;
#(
  parameter int unsigned N          = DEFAULT_N,
  parameter int unsigned FAIL_LIMIT = DEFAULT_FAIL_LIMIT,
  parameter int unsigned CNT_W      = DEFAULT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  rng_health_monitor_if.slave   bus
);

  localparam int unsigned       StreakW   = $clog2(FAIL_LIMIT + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(FAIL_LIMIT);
  localparam logic [CNT_W-1:0]   CntMax    = '1;

  logic sample_stb;

  rng_window_timer #(
    .N (N)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .sample_stb_o (sample_stb)
  );

  state_e             state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic [CNT_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic               ok_q, ok_d;
  logic               alarm_q, alarm_d;
  logic               bit_valid_q, bit_valid_d;
  logic               bit_q;
  logic               result_valid_q;
  logic               fail;
  logic               clr;

  // Next-state: statistics update on a sample, then state transitions.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    win_d    = win_q;
    fail_d   = fail_q;
    ok_d     = ok_q;
    fail     = ~bus.freq_pass;
    clr      = bus.alarm_clr && (state_q == StAlarm);

    if (sample_stb) begin
      ok_d = bus.freq_pass;
      if (win_q != CntMax) win_d = win_q + 1'b1;
      if (fail) begin
        if (fail_q != CntMax) fail_d = fail_q + 1'b1;
        if (streak_q != StreakMax) streak_d = streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end

    unique case (state_q)
      // A first-window failure that already hits the limit (FAIL_LIMIT=1) alarms at once.
      StWarmup: if (sample_stb) state_d = (streak_d == StreakMax) ? StAlarm : StRun;
      StRun:    if (sample_stb && fail && (streak_d == StreakMax)) state_d = StAlarm;
      // Clear wins over a coincident failing sample.
      StAlarm: begin
        if (clr) begin
          state_d  = StRun;
          streak_d = '0;
        end
      end
      default:  state_d = StWarmup;
    endcase

    alarm_d     = (state_d == StAlarm);
    bit_valid_d = (state_d == StRun) && ok_d;
  end

  // State, statistics and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StWarmup;
      streak_q       <= '0;
      win_q          <= '0;
      fail_q         <= '0;
      ok_q           <= 1'b0;
      alarm_q        <= 1'b0;
      bit_valid_q    <= 1'b0;
      bit_q          <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      streak_q       <= streak_d;
      win_q          <= win_d;
      fail_q         <= fail_d;
      ok_q           <= ok_d;
      alarm_q        <= alarm_d;
      bit_valid_q    <= bit_valid_d;
      bit_q          <= bus.rand_in;
      result_valid_q <= sample_stb;
    end
  end

  assign bus.bit_out      = bit_q;
  assign bus.bit_valid    = bit_valid_q;
  assign bus.result_valid = result_valid_q;
  assign bus.window_ok    = ok_q;
  assign bus.alarm        = alarm_q;
  assign bus.fail_streak  = streak_q;
  assign bus.win_count    = win_q;
  assign bus.fail_count   = fail_q;

endmodule

// File: tb/tb_rng_health_monitor.sv
// Bench: frequency-stage model feeding the monitor, scoreboard of per-window verdicts.
module tb_rng_health_monitor;

  localparam int unsigned N   = 16;
  localparam int unsigned FL  = 2;
  localparam int unsigned CW  = 16;
  localparam int unsigned CW2 = 2;
  localparam int unsigned SW  = $clog2(FL + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rand_in = 1'b0;
  logic alarm_clr = 1'b0;
  logic freq_pass;

  always #5 clk = ~clk;

  rng_health_monitor_if #(.FAIL_LIMIT(FL), .CNT_W(CW))  bus1 ();
  rng_health_monitor_if #(.FAIL_LIMIT(FL), .CNT_W(CW2)) bus2 ();

  assign bus1.rand_in   = rand_in;
  assign bus1.freq_pass = freq_pass;
  assign bus1.alarm_clr = alarm_clr;
  assign bus2.rand_in   = rand_in;
  assign bus2.freq_pass = freq_pass;
  assign bus2.alarm_clr = alarm_clr;

  rng_health_monitor #(.N(N), .FAIL_LIMIT(FL), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  rng_health_monitor #(.N(N), .FAIL_LIMIT(FL), .CNT_W(CW2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Frequency stage model: window bits on edges 1..N, verdict (6..10 ones) on edge N+1.
  int   fs_phase, fs_ones;
  logic fs_done, fs_verdict;
  always @(posedge clk) begin
    if (rst) begin
      fs_phase <= 0; fs_ones <= 0; fs_done <= 1'b0; fs_verdict <= 1'b0; freq_pass <= 1'b0;
    end else begin
      if (fs_phase == N - 1) begin
        fs_verdict <= (fs_ones + int'(rand_in) >= 6) && (fs_ones + int'(rand_in) <= 10);
        fs_done    <= 1'b1;
        fs_ones    <= 0;
        fs_phase   <= 0;
      end else begin
        fs_ones  <= fs_ones + int'(rand_in);
        fs_phase <= fs_phase + 1;
        fs_done  <= 1'b0;
      end
      if (fs_done) freq_pass <= fs_verdict;
    end
  end

  typedef struct {
    logic ok;
    int   streak;
    logic alarm;
    int   win;
    int   fail;
    int   win2;
    int   fail2;
    logic bv;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_n = 0;
  int   w_idx = 0;
  bit   clr_sched [0:15];
  logic exp_bv = 1'b0;
  logic exp_alarm = 1'b0;

  // Reference model: 0 warmup, 1 run, 2 alarm.
  int   m_state, m_streak, m_win, m_fail, m_win2, m_fail2;
  logic m_ok;

  function automatic int sat(input int x, input int mx);
    return (x >= mx) ? mx : x + 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_streak = 0; m_win = 0; m_fail = 0; m_win2 = 0; m_fail2 = 0; m_ok = 1'b0;
    sb_q.delete();
    w_idx = 0;
    exp_bv = 1'b0;
    exp_alarm = 1'b0;
    for (int i = 0; i < 16; i++) clr_sched[i] = 1'b0;
  endtask

  task automatic model_sample(input logic v, input bit c);
    exp_t e;
    m_ok   = v;
    m_win  = sat(m_win, (1 << CW) - 1);
    m_win2 = sat(m_win2, (1 << CW2) - 1);
    if (!v) begin
      m_fail   = sat(m_fail, (1 << CW) - 1);
      m_fail2  = sat(m_fail2, (1 << CW2) - 1);
      m_streak = sat(m_streak, FL);
    end else begin
      m_streak = 0;
    end
    if (m_state == 0) m_state = (m_streak == FL) ? 2 : 1;
    else if (m_state == 1) begin
      if (!v && m_streak == FL) m_state = 2;
    end else if (c) begin
      m_state  = 1;
      m_streak = 0;
    end
    e.ok = m_ok; e.streak = m_streak; e.alarm = (m_state == 2);
    e.win = m_win; e.fail = m_fail; e.win2 = m_win2; e.fail2 = m_fail2;
    e.bv = (m_state == 1) && m_ok;
    sb_q.push_back(e);
  endtask

  // One clock: advance, then check per-cycle outputs and any due verdict.
  task automatic cycle();
    logic prev_in, was_rst, exp_rv, exp_bo;
    exp_t e;
    prev_in = rand_in;
    was_rst = rst;
    @(posedge clk);
    #1;
    if (was_rst) edge_n = 0;
    else edge_n++;
    exp_bo = was_rst ? 1'b0 : prev_in;
    exp_rv = !was_rst && (edge_n >= N + 2) && ((edge_n - 2) % N == 0);
    n_cmp++;
    if (bus1.bit_out !== exp_bo) begin
      n_err++;
      $display("FAIL bit_out edge %0d: got %b want %b", edge_n, bus1.bit_out, exp_bo);
    end
    n_cmp++;
    if (bus1.result_valid !== exp_rv) begin
      n_err++;
      $display("FAIL result_valid edge %0d: got %b want %b", edge_n, bus1.result_valid, exp_rv);
    end
    if (bus1.result_valid === 1'b1 && exp_rv) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard edge %0d: got verdict, want none queued", edge_n);
      end else begin
        e = sb_q.pop_front();
        exp_bv = e.bv;
        exp_alarm = e.alarm;
        if (bus1.window_ok !== e.ok) begin
          n_err++;
          $display("FAIL window_ok edge %0d: got %b want %b", edge_n, bus1.window_ok, e.ok);
        end
        n_cmp++;
        if (bus1.fail_streak !== SW'(e.streak)) begin
          n_err++;
          $display("FAIL fail_streak edge %0d: got %0d want %0d", edge_n, bus1.fail_streak,
                   e.streak);
        end
        n_cmp++;
        if (bus1.win_count !== CW'(e.win)) begin
          n_err++;
          $display("FAIL win_count edge %0d: got %0d want %0d", edge_n, bus1.win_count, e.win);
        end
        n_cmp++;
        if (bus1.fail_count !== CW'(e.fail)) begin
          n_err++;
          $display("FAIL fail_count edge %0d: got %0d want %0d", edge_n, bus1.fail_count,
                   e.fail);
        end
        n_cmp++;
        if (bus2.win_count !== CW2'(e.win2)) begin
          n_err++;
          $display("FAIL sat win_count edge %0d: got %0d want %0d", edge_n, bus2.win_count,
                   e.win2);
        end
        n_cmp++;
        if (bus2.fail_count !== CW2'(e.fail2)) begin
          n_err++;
          $display("FAIL sat fail_count edge %0d: got %0d want %0d", edge_n, bus2.fail_count,
                   e.fail2);
        end
      end
    end
    n_cmp++;
    if (bus1.bit_valid !== exp_bv) begin
      n_err++;
      $display("FAIL bit_valid edge %0d: got %b want %b", edge_n, bus1.bit_valid, exp_bv);
    end
    n_cmp++;
    if (bus1.alarm !== exp_alarm) begin
      n_err++;
      $display("FAIL alarm edge %0d: got %b want %b", edge_n, bus1.alarm, exp_alarm);
    end
  endtask

  // Drive one bit for the next edge; pulse alarm_clr if that edge is a scheduled sample.
  task automatic drive_bit(input logic b);
    int u;
    rand_in = b;
    u = edge_n + 1;
    alarm_clr = 1'b0;
    if (!rst && u >= N + 2 && ((u - 2) % N == 0) && ((u - 2) / N) < 16)
      alarm_clr = clr_sched[(u - 2) / N];
    cycle();
  endtask

  task automatic run_window(input logic [15:0] pat);
    int ones;
    ones = 0;
    for (int i = 0; i < N; i++) begin
      drive_bit(pat[i]);
      ones += int'(pat[i]);
    end
    w_idx++;
    model_sample((ones >= 6) && (ones <= 10), clr_sched[w_idx]);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < cycles; i++) drive_bit(1'b0);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    n_cmp++;
    if (sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending verdicts want 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    n_cmp++;
    if ({bus1.bit_out, bus1.bit_valid, bus1.result_valid, bus1.window_ok, bus1.alarm} !== 5'b0)
    begin
      n_err++;
      $display("FAIL reset flags: got %b want 00000", {bus1.bit_out, bus1.bit_valid,
               bus1.result_valid, bus1.window_ok, bus1.alarm});
    end
    n_cmp++;
    if ({bus1.fail_streak, bus1.win_count, bus1.fail_count} !== '0) begin
      n_err++;
      $display("FAIL reset counters: got %0d/%0d/%0d want 0/0/0", bus1.fail_streak,
               bus1.win_count, bus1.fail_count);
    end
  endtask

  task automatic test_all_zero();
    do_reset(2);
    for (int w = 0; w < 3; w++) run_window(16'h0000);
    drain();
    n_cmp++;
    if (bus1.fail_count !== CW'(3) || bus1.win_count !== CW'(3)) begin
      n_err++;
      $display("FAIL all_zero counts: got %0d/%0d want 3/3", bus1.win_count, bus1.fail_count);
    end
  endtask

  task automatic test_alternating();
    do_reset(2);
    for (int w = 0; w < 3; w++) run_window(16'h5555);
    drain();
    n_cmp++;
    if (bus1.bit_valid !== 1'b1) begin
      n_err++;
      $display("FAIL alternating bit_valid: got %b want 1", bus1.bit_valid);
    end
  endtask

  task automatic test_pattern();
    logic [15:0] pats [5];
    pats = '{16'h00FF, 16'h0000, 16'h00FF, 16'h0000, 16'h0000};
    do_reset(2);
    for (int w = 0; w < 5; w++) run_window(pats[w]);
    drain();
  endtask

  task automatic test_alarm_clear();
    logic [15:0] pats [5];
    pats = '{16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'h0000};
    do_reset(2);
    clr_sched[3] = 1'b1;
    for (int w = 0; w < 5; w++) run_window(pats[w]);
    drain();
  endtask

  task automatic test_reset_mid_window();
    do_reset(2);
    run_window(16'h5555);
    for (int i = 0; i < 8; i++) drive_bit(i[0]);
    do_reset(1);
    n_cmp++;
    if ({bus1.bit_valid, bus1.window_ok, bus1.alarm, bus1.win_count} !== '0) begin
      n_err++;
      $display("FAIL mid reset: got bv=%b ok=%b alarm=%b win=%0d want all 0", bus1.bit_valid,
               bus1.window_ok, bus1.alarm, bus1.win_count);
    end
    run_window(16'h5555);
    drain();
  endtask

  task automatic test_saturation();
    do_reset(2);
    for (int i = 1; i <= 5; i++) clr_sched[i] = 1'b1;
    for (int w = 0; w < 5; w++) run_window(16'h0000);
    drain();
    n_cmp++;
    if (bus2.win_count !== 2'd3 || bus2.fail_count !== 2'd3) begin
      n_err++;
      $display("FAIL saturation: got %0d/%0d want 3/3", bus2.win_count, bus2.fail_count);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_all_zero();
    test_alternating();
    test_pattern();
    test_alarm_clear();
    test_reset_mid_window();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/rng_health_monitor.md
Name: rng_health_monitor

Overview:
- Downstream consumer of the FIPS monobit frequency-test stage in the PUF/TRNG health chain.
- Runs a window timer locked to the frequency stage's N-bit windows and samples its pass flag once per window.
- Keeps pass/fail statistics and counts consecutive failures; raises a sticky alarm at a limit.
- Gates the raw random bit stream so that only bits from a healthy source reach consumers.

Parameters:
- N, 20000, bits per test window; must match the frequency stage.
- FAIL_LIMIT, 3, consecutive failed windows that raise the alarm (>=1).
- CNT_W, 16, width of the window and fail statistic counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rand_in  in  1  raw random bit, one per clk; the same stream that feeds the frequency stage
- freq_pass  in  1  pass flag from the frequency stage
- alarm_clr  in  1  one-cycle request to leave ALARM
- bit_out  out  1  registered copy of rand_in
- bit_valid  out  1  bit_out is certified usable
- result_valid  out  1  one-cycle pulse on each window verdict
- window_ok  out  1  verdict of the most recent window
- alarm  out  1  sticky health alarm
- fail_streak  out  $clog2(FAIL_LIMIT+1)  current consecutive-fail count
- win_count  out  CNT_W  windows evaluated since reset
- fail_count  out  CNT_W  failed windows since reset

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk. Reset is asserted simultaneously to this block and the frequency stage.
- Reset values: bit_out 0, bit_valid 0, result_valid 0, window_ok 0, alarm 0, fail_streak 0, win_count 0, fail_count 0, state WARMUP.
- Timing contract:
  - Number the first rising edge after rst deasserts as edge 1.
  - The frequency stage updates freq_pass on edge k*N+1 for window k (k>=1).
  - This block samples freq_pass on edge k*N+2.
  - result_valid is high for exactly the cycle after that sample edge.
  - The window timer is a modulo-N phase counter plus a 2-cycle start offset. Never sample between windows.
- On each sample:
  - window_ok <= freq_pass.
  - win_count increments, saturating at all-ones.
  - On fail, fail_count increments (saturating) and fail_streak increments, saturating at FAIL_LIMIT.
  - On pass, fail_streak <= 0.
- States:
  - WARMUP: entered on reset. bit_valid=0. The first sample goes to RUN, whatever the verdict.
  - RUN: bit_valid = window_ok, registered so it aligns with bit_out. If a fail makes fail_streak reach FAIL_LIMIT, go to ALARM; alarm=1 on the same edge that fail_streak reaches the limit.
  - ALARM: alarm=1, bit_valid=0. Samples and statistics continue. alarm_clr=1 sets fail_streak <= 0, alarm <= 0 and goes to RUN on the next edge.
- bit_out <= rand_in every cycle, including WARMUP and ALARM; latency 1.
- alarm_clr outside ALARM is ignored.
- alarm_clr on the same edge as a failing sample:
  - clear wins; fail_streak <= 0 and state RUN.
  - win_count/fail_count still record the sample.
  - window_ok <= 0, so bit_valid stays 0 until a passing window.
- Reset mid-window: all state, statistics and timer phase return to reset values; the next sample is on edge N+2 after release.
- FAIL_LIMIT=1: a single failing window alarms.

Decomposition:
- Shared package rng_health_pkg holds:
  - state enum (WARMUP, RUN, ALARM)
  - default N, FAIL_LIMIT, CNT_W
  - SAMPLE_OFFSET=2
- Sub-module rng_window_timer(N): phase counter with start offset; emits sample_stb on edges k*N+2. Reused by future runs/poker test monitors.

Test Plan (bench overrides N=16, FAIL_LIMIT=2; bench instantiates the frequency stage with N=16, band 6..10):
- All-zero rand for 3 windows -> result_valid pulses after edges 18, 34, 50; window_ok=0 each time; fail_streak 1 then 2; alarm=1 after edge 34; bit_valid stays 0; fail_count=3, win_count=3.
- Alternating 0/1 stream -> every window passes; state reaches RUN after edge 18; bit_valid=1 from the cycle after that; bit_out equals rand_in delayed 1; alarm=0.
- Pass, fail, pass, fail, fail pattern (8-one windows vs 0-one windows) -> fail_streak sequence 0,1,0,1,2; alarm rises only on the fifth sample.
- In ALARM, pulse alarm_clr on a failing sample edge -> alarm=0 next cycle, state RUN, fail_streak=0, fail_count incremented, bit_valid=0 until the next passing window.
- Assert rst for 1 cycle at edge 25 mid-window -> all outputs return to zero; the next result_valid follows edge N+2=18 after release.
- CNT_W=2, 5 failing windows with alarm_clr pulsed each time -> win_count and fail_count saturate at 3.
